// File: rtl/scr1_acc_pkg.sv
// Shared types and widths for the TCM copy-accelerator arbiter.
// Used by scr1_acc_tcm_arb and scr1_acc_arb_rdroute.
package scr1_acc_pkg;

  localparam int SCR1_ACC_TCM_AW = 14;
  localparam int SCR1_ACC_TCM_DW = 32;

  typedef enum logic [1:0] {
    IDLE,
    CORE,
    ACC
  } type_acc_arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CORE,
    OWN_ACC
  } type_acc_arb_owner_e;

endpackage

// File: rtl/scr1_acc_arb_rdroute.sv
// Read-return routing: remembers who owns the TCM read in flight and steers tcm_rdata
// to that requester one cycle after the read grant.
module scr1_acc_arb_rdroute
  import scr1_acc_pkg::*;
#(
  parameter int DW = SCR1_ACC_TCM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          core_rd_gnt,
  input  logic          acc_rd_gnt,
  input  logic [DW-1:0] tcm_rdata,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  output logic          acc_rvalid,
  output logic [DW-1:0] acc_rdata
);

  type_acc_arb_owner_e owner_q, owner_d;
  logic [DW-1:0]       acc_rdata_q, acc_rdata_d;

  always_comb begin
    owner_d = OWN_NONE;
    if (core_rd_gnt) begin
      owner_d = OWN_CORE;
    end else if (acc_rd_gnt) begin
      owner_d = OWN_ACC;
    end
  end

  // The accelerator sees its data in the return cycle; the register keeps it afterwards.
  always_comb begin
    acc_rdata_d = acc_rdata_q;
    if (owner_q == OWN_ACC) begin
      acc_rdata_d = tcm_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= OWN_NONE;
      acc_rdata_q <= '0;
    end else begin
      owner_q     <= owner_d;
      acc_rdata_q <= acc_rdata_d;
    end
  end

  assign core_rvalid = (owner_q == OWN_CORE);
  assign core_rdata  = core_rvalid ? tcm_rdata : '0;
  assign acc_rvalid  = (owner_q == OWN_ACC);
  assign acc_rdata   = acc_rvalid ? tcm_rdata : acc_rdata_q;

endmodule

// File: rtl/scr1_acc_tcm_arb.sv
// Single-port data TCM arbiter between the core DMEM path and the copy accelerator.
// Optional SCR1_ACC_ARB_FAIRNESS_EN bounds how long the accelerator may starve the core.
module scr1_acc_tcm_arb
  import scr1_acc_pkg::*;
#(
  parameter int AW         = SCR1_ACC_TCM_AW,
  parameter int DW         = SCR1_ACC_TCM_DW,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  input  logic [3:0]    core_be,
  output logic          core_gnt,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  input  logic          acc_en,
  input  logic          acc_ren,
  input  logic          acc_wen,
  input  logic [AW-1:0] acc_addr,
  input  logic [DW-1:0] acc_wdata,
  input  logic [3:0]    acc_be,
  output logic          acc_gnt,
  output logic          acc_rvalid,
  output logic [DW-1:0] acc_rdata,
  output logic          tcm_cs,
  output logic          tcm_we,
  output logic [AW-1:0] tcm_addr,
  output logic [DW-1:0] tcm_wdata,
  output logic [3:0]    tcm_be,
  input  logic [DW-1:0] tcm_rdata
);

  type_acc_arb_state_e state_q, state_d;
  logic                acc_req;
  logic                acc_is_write;
  logic                core_force;
  logic                core_rd_gnt;
  logic                acc_rd_gnt;

  assign acc_req      = acc_en & (acc_ren | acc_wen);
  // Both enables together is illegal; resolving it as a write never returns stale data.
  assign acc_is_write = acc_wen;

`ifdef SCR1_ACC_ARB_FAIRNESS_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  assign core_force = core_req & (starve_cnt_q == CNT_W'(STARVE_MAX));

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!core_req || (state_d == CORE)) begin
      starve_cnt_d = '0;
    end else if (state_d == ACC) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  logic unused_cfg;

  assign core_force = 1'b0;
  assign unused_cfg = |STARVE_MAX;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant is decided from live requests each cycle; nothing reaches the TCM while in reset.
  always_comb begin
    state_d = IDLE;
    if (!rst_n) begin
      state_d = IDLE;
    end else if (core_force) begin
      state_d = CORE;
    end else if (acc_req) begin
      state_d = ACC;
    end else if (core_req) begin
      state_d = CORE;
    end
  end

  always_comb begin
    core_gnt    = 1'b0;
    acc_gnt     = 1'b0;
    tcm_cs      = 1'b0;
    tcm_we      = 1'b0;
    tcm_addr    = '0;
    tcm_wdata   = '0;
    tcm_be      = '0;
    core_rd_gnt = 1'b0;
    acc_rd_gnt  = 1'b0;
    unique case (state_d)
      CORE: begin
        core_gnt    = 1'b1;
        tcm_cs      = 1'b1;
        tcm_we      = core_we;
        tcm_addr    = core_addr;
        tcm_wdata   = core_wdata;
        tcm_be      = core_be;
        core_rd_gnt = ~core_we;
      end
      ACC: begin
        acc_gnt    = 1'b1;
        tcm_cs     = 1'b1;
        tcm_we     = acc_is_write;
        tcm_addr   = acc_addr;
        tcm_wdata  = acc_wdata;
        tcm_be     = acc_be;
        acc_rd_gnt = ~acc_is_write;
      end
      default: begin
      end
    endcase
  end

  // state_q holds the previous cycle's grant and is kept as a debug observation point.
  logic unused_state;
  assign unused_state = ^state_q;

  scr1_acc_arb_rdroute #(
    .DW (DW)
  ) i_rdroute (
    .clk         (clk),
    .rst_n       (rst_n),
    .core_rd_gnt (core_rd_gnt),
    .acc_rd_gnt  (acc_rd_gnt),
    .tcm_rdata   (tcm_rdata),
    .core_rvalid (core_rvalid),
    .core_rdata  (core_rdata),
    .acc_rvalid  (acc_rvalid),
    .acc_rdata   (acc_rdata)
  );

endmodule

// File: doc/scr1_acc_tcm_arb.md
Name: scr1_acc_tcm_arb

Overview:
- Downstream of the TCM copy accelerator. Arbitrates the single-port data TCM between the SCR1 core DMEM path and the accelerator's memory port (read-source / write-destination accesses).
- Stalls the loser of each arbitration and tracks the 1-cycle TCM read latency. Routes returned read data to whichever requester owns it.
- The whole module is compiled only under SCR1_TCM_EN.

Parameters:
- AW, 14, word-address width (byte address bits [15:2])
- DW, 32, data width
- STARVE_MAX, 4, maximum consecutive ACC grants while a core request waits (fairness option only)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- core_req  in  1  core access request, held until core_gnt
- core_we  in  1  1 = write, 0 = read
- core_addr  in  AW  core word address
- core_wdata  in  DW  core write data
- core_be  in  4  core byte enables
- core_gnt  out  1  core access accepted this cycle
- core_rvalid  out  1  core read data valid
- core_rdata  out  DW  core read data
- acc_en  in  1  accelerator transaction active
- acc_ren  in  1  accelerator read request, held until acc_gnt
- acc_wen  in  1  accelerator write request, held until acc_gnt
- acc_addr  in  AW  accelerator word address
- acc_wdata  in  DW  accelerator write data
- acc_be  in  4  accelerator byte enables
- acc_gnt  out  1  accelerator access accepted this cycle
- acc_rvalid  out  1  accelerator read data valid
- acc_rdata  out  DW  accelerator read data, held until the next acc read returns
- tcm_cs  out  1  TCM chip select
- tcm_we  out  1  TCM write enable
- tcm_addr  out  AW  TCM word address
- tcm_wdata  out  DW  TCM write data
- tcm_be  out  4  TCM byte enables
- tcm_rdata  in  DW  TCM read data, valid 1 cycle after read select

Behaviour:
- Reset: all outputs 0; acc_rdata = 0; owner tag = NONE; starve counter = 0; FSM = IDLE.
- Requests:
  - acc_req = acc_en & (acc_ren | acc_wen).
  - acc_ren and acc_wen both high is illegal and treated as a write.
- FSM states:
  - IDLE: no grant.
  - CORE: core granted this cycle.
  - ACC: accelerator granted this cycle.
  - Next state is evaluated every cycle from the live requests, so back-to-back grants are allowed and there are no dead cycles.
- Priority:
  - acc_req beats core_req.
  - If only one requester is active, it wins.
  - If neither is active, the FSM goes to IDLE and tcm_cs = 0.
- Grant cycle:
  - tcm_cs = 1, and tcm_we/addr/wdata/be are driven combinationally from the winner.
  - The winner's gnt = 1. The loser's gnt = 0 and it must hold its request unchanged.
- Write latency: write completes in the grant cycle; no response beyond gnt.
- Read latency:
  - On a read grant, the owner tag is registered (CORE or ACC).
  - In the next cycle, tcm_rdata is routed to the owner: core_rdata with core_rvalid = 1 for 1 cycle, or acc_rdata registered from tcm_rdata with acc_rvalid pulsed.
  - core_rdata = 0 when core_rvalid = 0.
- Pipelining: a new grant may issue in the same cycle as the previous read's data return.
- acc_en deassertion:
  - If acc_en drops while an ACC read is in flight, the data is still delivered to acc_rdata.
  - A request is never granted without acc_en.
- Reset mid-operation: any in-flight rvalid is dropped; no stale pulse after rst_n rises.

Optional Feature:
- Macro: SCR1_ACC_ARB_FAIRNESS_EN.
- With the macro:
  - A starvation counter increments on each ACC grant while core_req = 1, and clears on any core grant or when core_req = 0.
  - When the counter equals STARVE_MAX and core_req = 1, the core wins the next arbitration regardless of acc_req; the counter then clears.
- Without the macro: strict ACC priority; the counter is absent.

Decomposition:
- Shared package scr1_acc_pkg holds:
  - enum type_acc_arb_state_e {IDLE, CORE, ACC};
  - enum type_acc_arb_owner_e {OWN_NONE, OWN_CORE, OWN_ACC};
  - localparam SCR1_ACC_TCM_AW = 14.
- One natural sub-module: scr1_acc_arb_rdroute, holding the owner tag register plus read-data demux and acc_rdata hold register.

Test Plan:
- Core-only read: core_req = 1, we = 0, addr = 14'h0010, TCM word = 32'hDEADBEEF -> core_gnt in cycle 0; core_rvalid = 1 with core_rdata = 32'hDEADBEEF in cycle 1; acc_rvalid stays 0.
- Collision: core_req read addr 14'h0001 and acc_ren addr 14'h0002 asserted in the same cycle -> acc_gnt first with tcm_addr = 14'h0002; core_gnt next cycle with tcm_addr = 14'h0001; each rvalid goes to the correct side with the correct data.
- ACC copy: acc_en = 1, read addr 14'h0004 (holds 32'h12345678), then write addr 14'h0008 -> acc_rdata = 32'h12345678 one cycle after the read grant; the TCM word at 14'h0008 reads back 32'h12345678 via the core.
- Starvation:
  - With SCR1_ACC_ARB_FAIRNESS_EN and STARVE_MAX = 4, acc_req held continuously while core_req = 1 -> core_gnt exactly on the 5th arbitration, then ACC resumes.
  - Without the macro -> no core_gnt until acc_req drops.
- Reset mid-read: assert rst_n = 0 in the cycle after an ACC read grant -> acc_rvalid = 0, acc_rdata = 0, and no rvalid after release.
- acc_ren = 1 with acc_en = 0 -> acc_gnt = 0 and tcm_cs = 0; a pending core request is granted immediately.
